tnn_neuron_sched: RTL



---
 rtl/tnn_sched_pkg.sv | 18 +
 rtl/tnn_cfg_table.sv | 52 +++++
 rtl/tnn_neuron_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tnn_sched_pkg.sv
// Shared types for the TNN neuron scheduler.
// Operand width, slot count and FSM encoding.
package tnn_sched_pkg;

  localparam int FEAT_W = 3;
  localparam int N_OPS  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [FEAT_W-1:0] op_t;
  typedef logic [2:0]        slot_t;

endpackage

// File: rtl/tnn_cfg_table.sv
// Per-neuron feature routing table with guarded writes.
// Read side yields the five operands of one neuron.
import tnn_sched_pkg::*;

module tnn_cfg_table #(
  parameter int NUM_FEAT    = 11,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 4,
  parameter int NW          = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_allow,
  input  logic                       cfg_we,
  input  logic [NW-1:0]              cfg_neuron,
  input  slot_t                      cfg_slot,
  input  logic [IDX_W-1:0]           cfg_idx,
  output logic                       cfg_err,
  input  logic [NW-1:0]              rd_neuron,
  input  logic [NUM_FEAT*FEAT_W-1:0] feat,
  output op_t  [N_OPS-1:0]           ops
);

  logic [IDX_W-1:0] tbl [NUM_NEURONS][N_OPS];
  logic             wr_ok;

  assign wr_ok = wr_allow && (cfg_slot < slot_t'(N_OPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int s = 0; s < N_OPS; s++)
          tbl[n][s] <= IDX_W'(s);
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      if (cfg_we && wr_ok)
        tbl[cfg_neuron][cfg_slot] <= cfg_idx;
    end
  end

  // Indices past the last feature fall through to zero.
  always_comb begin
    for (int s = 0; s < N_OPS; s++) begin
      ops[s] = '0;
      for (int f = 0; f < NUM_FEAT; f++)
        if (tbl[rd_neuron][s] == IDX_W'(f))
          ops[s] = feat[f*FEAT_W +: FEAT_W];
    end
  end

endmodule

// File: rtl/tnn_neuron_sched.sv
// Time-multiplexes one threshold-neuron core over a layer.
// Captures a feature vector, sweeps neurons, returns decisions.
import tnn_sched_pkg::*;

module tnn_neuron_sched #(
  parameter int NUM_FEAT    = 11,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_FEAT+1),
  localparam int NW         = $clog2(NUM_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_NEURONS-1:0]     out_vec,
  input  logic                       cfg_we,
  input  logic [NW-1:0]              cfg_neuron,
  input  slot_t                      cfg_slot,
  input  logic [IDX_W-1:0]           cfg_idx,
  output logic                       cfg_err,
  output op_t                        core_a,
  output op_t                        core_b,
  output op_t                        core_c,
  output op_t                        core_d,
  output op_t                        core_e,
  input  logic                       core_out
);

  state_t                     state, state_nx;
  logic [NW-1:0]              n;
  logic [NUM_FEAT*FEAT_W-1:0] feat_q;
  op_t  [N_OPS-1:0]           ops;
  logic                       last;

  assign last = (n == NW'(NUM_NEURONS-1));

  tnn_cfg_table #(
    .NUM_FEAT    (NUM_FEAT),
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .NW          (NW)
  ) u_tbl (
    .clk        (clk),
    .rst        (rst),
    .wr_allow   ((state == IDLE) && !in_valid),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_slot   (cfg_slot),
    .cfg_idx    (cfg_idx),
    .cfg_err    (cfg_err),
    .rd_neuron  (n),
    .feat       (feat_q),
    .ops        (ops)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid)  state_nx = RUN;
      RUN:   if (last)      state_nx = DRAIN;
      DRAIN:                state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // core_out reflects the operands loaded on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      n       <= '0;
      feat_q  <= '0;
      out_vec <= '0;
      core_a  <= '0;
      core_b  <= '0;
      core_c  <= '0;
      core_d  <= '0;
      core_e  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q <= in_feat;
            n      <= '0;
          end
        end
        RUN: begin
          core_a <= ops[0];
          core_b <= ops[1];
          core_c <= ops[2];
          core_d <= ops[3];
          core_e <= ops[4];
          n      <= n + NW'(1);
          if (n != '0)
            out_vec[n - NW'(1)] <= core_out;
        end
        DRAIN: out_vec[NUM_NEURONS-1] <= core_out;
        DONE: begin
          if (out_ready) begin
            core_a <= '0;
            core_b <= '0;
            core_c <= '0;
            core_d <= '0;
            core_e <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
